// File: rtl/avl_resp_pkg.sv
// Shared types and default widths for the Avalon-MM memory responder.
package avl_resp_pkg;

  localparam int unsigned AvlAddrW = 26;
  localparam int unsigned AvlDataW = 128;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StStall,
    StAccept
  } avl_state_e;

  // One slot of the read-latency pipe; data width is the widest supported bus.
  typedef struct packed {
    logic                valid;
    logic [AvlDataW-1:0] data;
  } lat_entry_t;

endpackage

// File: rtl/avl_resp_ram.sv
// Single-port backing RAM: synchronous write, registered read-first output.
module avl_resp_ram
  import avl_resp_pkg::*;
#(
  parameter int unsigned DataW     = AvlDataW,
  parameter int unsigned DepthLog2 = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [DepthLog2-1:0] addr_i,
  input  logic [DataW-1:0]     wdata_i,
  output logic [DataW-1:0]     rdata_o
);

  logic [DataW-1:0] mem_q [2**DepthLog2];
  logic [DataW-1:0] rdata_q;

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Output holds its value between reads.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM memory responder with wait-states, fixed read latency and init delay.
// Define AVL_RESP_ERRINJ_EN to invert bit 0 of every read from word INJ_ADDR.
module avl_mem_responder
  import avl_resp_pkg::*;
#(
  parameter int unsigned ADDR_W     = AvlAddrW,
  parameter int unsigned DATA_W     = AvlDataW,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WAIT_CYC   = 2,
  parameter int unsigned READ_LAT   = 4,
  parameter int unsigned INIT_CYC   = 32,
  parameter int unsigned INJ_ADDR   = 5
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [DATA_W-1:0] avl_writedata,
  input  logic              avl_burstbegin,
  output logic              avl_waitrequest_n,
  output logic              avl_readdatavalid,
  output logic [DATA_W-1:0] avl_readdata,
  output logic              local_init_done,
  output logic              proto_err
);

  localparam int unsigned InitW = $clog2(INIT_CYC + 1);
`ifdef AVL_RESP_ERRINJ_EN
  localparam bit InjEn = 1'b1;
`else
  localparam bit InjEn = 1'b0;
`endif

  avl_state_e            state_q, state_d;
  logic [InitW-1:0]      init_cnt_q, init_cnt_d;
  logic [3:0]            stall_cnt_q, stall_cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic                  init_done_q, init_done_d;
  logic                  proto_err_q, proto_err_d;
  logic                  wrn_q;
  logic                  rd_issue_q;
  logic                  inj_q;
  logic                  cmd_live;
  logic                  ram_we, ram_re;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_rdata;
  lat_entry_t            head, tail;
  logic                  unused_sig;

  assign cmd_live   = avl_read | avl_write;
  assign ram_addr   = avl_address[DEPTH_LOG2-1:0];
  assign unused_sig = ^{avl_burstbegin, avl_address[ADDR_W-1:DEPTH_LOG2]};

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    stall_cnt_d = stall_cnt_q;
    is_wr_d     = is_wr_q;
    init_done_d = init_done_q;
    proto_err_d = proto_err_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    unique case (state_q)
      StInit: begin
        if (init_cnt_q == InitW'(INIT_CYC - 1)) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        stall_cnt_d = '0;
        if (cmd_live) begin
          // A simultaneous read+write is latched as a write.
          is_wr_d = avl_write;
          state_d = (WAIT_CYC == 0) ? StAccept : StStall;
        end
      end
      StStall: begin
        if (!cmd_live) begin
          state_d = StIdle;
        end else if (stall_cnt_q == 4'(WAIT_CYC - 1)) begin
          state_d = StAccept;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      StAccept: begin
        state_d = StIdle;
        if (!cmd_live || (avl_read && avl_write)) begin
          proto_err_d = 1'b1;
        end
        ram_we = cmd_live && is_wr_q;
        ram_re = cmd_live && !is_wr_q;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      stall_cnt_q <= '0;
      is_wr_q     <= 1'b0;
      init_done_q <= 1'b0;
      proto_err_q <= 1'b0;
      wrn_q       <= 1'b0;
      rd_issue_q  <= 1'b0;
      inj_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      is_wr_q     <= is_wr_d;
      init_done_q <= init_done_d;
      proto_err_q <= proto_err_d;
      wrn_q       <= (state_d == StAccept);
      rd_issue_q  <= ram_re;
      if (ram_re) begin
        inj_q <= InjEn & (ram_addr == DEPTH_LOG2'(INJ_ADDR));
      end
    end
  end

  avl_resp_ram #(
    .DataW    (DATA_W),
    .DepthLog2(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (iCLK),
    .rst_ni (iRST_n),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(avl_writedata),
    .rdata_o(ram_rdata)
  );

  // RAM output register is pipe stage 1; later stages load data only with a
  // valid token, so the tail holds the last returned word between pulses.
  assign head = '{valid: rd_issue_q, data: AvlDataW'(ram_rdata ^ DATA_W'(inj_q))};

  if (READ_LAT == 1) begin : g_lat1
    assign tail = head;
  end else begin : g_pipe
    lat_entry_t pipe_q [READ_LAT-1];

    always_ff @(posedge iCLK) begin
      if (!iRST_n) begin
        for (int i = 0; i < READ_LAT - 1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0].valid <= head.valid;
        if (head.valid) begin
          pipe_q[0].data <= head.data;
        end
        for (int i = 1; i < READ_LAT - 1; i++) begin
          pipe_q[i].valid <= pipe_q[i-1].valid;
          if (pipe_q[i-1].valid) begin
            pipe_q[i].data <= pipe_q[i-1].data;
          end
        end
      end
    end

    assign tail = pipe_q[READ_LAT-2];
  end

  assign avl_waitrequest_n = wrn_q;
  assign avl_readdatavalid = tail.valid;
  assign avl_readdata      = DATA_W'(tail.data);
  assign local_init_done   = init_done_q;
  assign proto_err         = proto_err_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Directed, table-driven bench for avl_mem_responder at default parameters.
module tb_avl_mem_responder;

  localparam int unsigned AW    = 26;
  localparam int unsigned DW    = 128;
  localparam int unsigned WAITC = 2;
  localparam int unsigned LAT   = 4;
  localparam int unsigned INITC = 32;

  localparam logic [DW-1:0] P0 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] P1 = 128'hDEADBEEF_00000000_FFFFFFFF_12345678;
`ifdef AVL_RESP_ERRINJ_EN
  localparam logic [DW-1:0] Inj5 = 128'h1;
`else
  localparam logic [DW-1:0] Inj5 = 128'h0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] avl_address;
  logic          avl_read, avl_write, avl_burstbegin;
  logic [DW-1:0] avl_writedata;
  logic          avl_waitrequest_n, avl_readdatavalid;
  logic [DW-1:0] avl_readdata;
  logic          local_init_done, proto_err;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  avl_mem_responder #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DEPTH_LOG2(10),
    .WAIT_CYC  (WAITC),
    .READ_LAT  (LAT),
    .INIT_CYC  (INITC),
    .INJ_ADDR  (5)
  ) dut (
    .iCLK             (clk),
    .iRST_n           (rst_n),
    .avl_address      (avl_address),
    .avl_read         (avl_read),
    .avl_write        (avl_write),
    .avl_writedata    (avl_writedata),
    .avl_burstbegin   (avl_burstbegin),
    .avl_waitrequest_n(avl_waitrequest_n),
    .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata     (avl_readdata),
    .local_init_done  (local_init_done),
    .proto_err        (proto_err)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE, hold it through the accept cycle, then
  // follow a read to its readdatavalid pulse.
  task automatic txn(input vec_t v, input string nm);
    int lat;
    int rl;
    avl_address   = v.addr;
    avl_writedata = v.wdata;
    avl_write     = v.wr;
    avl_read      = ~v.wr;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!avl_waitrequest_n && lat < 40);
    check({nm, " accept latency"}, DW'(lat), DW'(WAITC + 1));
    step();
    avl_write = 1'b0;
    avl_read  = 1'b0;
    if (!v.wr) begin
      rl = 1;
      while (!avl_readdatavalid && rl < 40) begin
        step();
        rl++;
      end
      check({nm, " read latency"}, DW'(rl), DW'(LAT));
      check({nm, " read data"}, avl_readdata, v.exp);
      step();
      check({nm, " valid pulse width"}, DW'(avl_readdatavalid), DW'(0));
      check({nm, " data held"}, avl_readdata, v.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_done;
    int first_wrn;
    int seen;
    vec_t v;

    vecs[0]  = '{1'b1, 26'd7,         P0,            P0};
    vecs[1]  = '{1'b0, 26'd7,         '0,            P0};
    vecs[2]  = '{1'b1, 26'd1027,      128'hA5,       128'hA5};
    vecs[3]  = '{1'b0, 26'd3,         '0,            128'hA5};
    vecs[4]  = '{1'b1, 26'd5,         '0,            '0};
    vecs[5]  = '{1'b0, 26'd5,         '0,            Inj5};
    vecs[6]  = '{1'b1, 26'd6,         '0,            '0};
    vecs[7]  = '{1'b0, 26'd6,         '0,            '0};
    vecs[8]  = '{1'b1, 26'h3FF,       P1,            P1};
    vecs[9]  = '{1'b0, 26'h3FFFFFF,   '0,            P1};
    vecs[10] = '{1'b0, 26'd7,         '0,            P0};
    vecs[11] = '{1'b1, 26'd3,         128'h5A,       128'h5A};
    vecs[12] = '{1'b0, 26'd1027,      '0,            128'h5A};

    rst_n          = 1'b0;
    avl_address    = '0;
    avl_read       = 1'b0;
    avl_write      = 1'b0;
    avl_writedata  = '0;
    avl_burstbegin = 1'b0;
    repeat (3) step();
    check("reset waitrequest_n", DW'(avl_waitrequest_n), DW'(0));
    check("reset readdatavalid", DW'(avl_readdatavalid), DW'(0));
    check("reset readdata", avl_readdata, '0);
    check("reset init_done", DW'(local_init_done), DW'(0));
    check("reset proto_err", DW'(proto_err), DW'(0));

    // Read held from reset release must wait for init, then see 2 stalls.
    avl_read = 1'b1;
    rst_n    = 1'b1;
    first_done = -1;
    first_wrn  = -1;
    for (int i = 1; i <= 60 && first_wrn < 0; i++) begin
      step();
      if (local_init_done && first_done < 0) first_done = i;
      if (avl_waitrequest_n) first_wrn = i;
    end
    check("init_done cycle", DW'(first_done), DW'(INITC));
    check("first accept cycle", DW'(first_wrn), DW'(INITC + WAITC + 1));
    step();
    avl_read = 1'b0;
    repeat (8) step();

    for (int i = 0; i < 13; i++) begin
      txn(vecs[i], $sformatf("vec%0d", i));
    end
    check("proto_err after clean traffic", DW'(proto_err), DW'(0));

    // Write abandoned during STALL: never accepted, RAM untouched.
    avl_address   = 26'd7;
    avl_writedata = ~P0;
    avl_write     = 1'b1;
    step();
    avl_write = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (avl_waitrequest_n) seen++;
    end
    check("abort no accept", DW'(seen), DW'(0));
    check("abort proto_err", DW'(proto_err), DW'(0));
    v = '{1'b0, 26'd7, '0, P0};
    txn(v, "abort readback");

    // read=write=1: committed as a write, no read return, sticky error.
    avl_address   = 26'd9;
    avl_writedata = 128'hC0FFEE;
    avl_write     = 1'b1;
    avl_read      = 1'b1;
    seen = 0;
    while (!avl_waitrequest_n && seen < 40) begin
      step();
      seen++;
    end
    check("conflict accept latency", DW'(seen), DW'(WAITC + 1));
    step();
    avl_write = 1'b0;
    avl_read  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (avl_readdatavalid) seen++;
      step();
    end
    check("conflict no readdatavalid", DW'(seen), DW'(0));
    check("conflict proto_err", DW'(proto_err), DW'(1));
    v = '{1'b0, 26'd9, '0, 128'hC0FFEE};
    txn(v, "conflict readback");
    check("proto_err sticky", DW'(proto_err), DW'(1));

    // Reset two cycles after a read accept flushes the in-flight return.
    avl_address = 26'd7;
    avl_read    = 1'b1;
    seen = 0;
    while (!avl_waitrequest_n && seen < 40) begin
      step();
      seen++;
    end
    check("mid-reset read accept", DW'(seen), DW'(WAITC + 1));
    step();
    avl_read = 1'b0;
    step();
    rst_n = 1'b0;
    seen  = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (avl_readdatavalid) seen++;
    end
    check("reset clears readdata", avl_readdata, '0);
    check("reset clears proto_err", DW'(proto_err), DW'(0));
    rst_n = 1'b1;
    first_done = 0;
    for (int i = 0; i < 60 && !local_init_done; i++) begin
      step();
      first_done++;
      if (avl_readdatavalid) seen++;
    end
    check("flushed read no readdatavalid", DW'(seen), DW'(0));
    check("re-init cycles", DW'(first_done), DW'(INITC));
    v = '{1'b0, 26'd7, '0, P0};
    txn(v, "post-reset readback");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
